// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-word handshake between the UART receiver (master) and the RX FIFO (slave).
interface uart_rx_core_if #(
    parameter int DATA_W = 9
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_parity;
    logic              rxwr_request;
    logic              rx_full;
    modport master (output rx_data, rx_parity, rxwr_request, input rx_full);
    modport slave (input rx_data, rx_parity, rxwr_request, output rx_full);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with 3-sample voting and sticky PE/FE/BRK/OE flags.
// Defining RX_NOISE_FLAG_EN adds a sticky noise flag NF with its clear input clearNF.
module uart_rx_core #(
    parameter int DATA_W     = 9,
    parameter int OVERSAMPLE = 16,
    parameter int IDLE_ONES  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_clk_enable,
    input  logic [3:0]     word_len,
    input  logic [1:0]     parity_mode,
    input  logic           stop2,
    input  logic           rxIn_pin,
    uart_rx_core_if.master fifo,
    output logic           PE,
    output logic           FE,
    output logic           BRK,
    output logic           OE,
    input  logic           clearPE,
    input  logic           clearFE,
    input  logic           clearBRK,
    input  logic           clearOE,
`ifdef RX_NOISE_FLAG_EN
    output logic           NF,
    input  logic           clearNF,
`endif
    output logic [2:0]     state
);
    typedef enum logic [2:0] {IDLE, HUNT, START, DATA, PARITY, STOP, BREAK} state_t;
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(IDLE_ONES + 1);
    localparam logic [PW-1:0] PH_S0   = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1   = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_S2   = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] ONES_LAST = CW'(IDLE_ONES - 1);

    state_t            st;
    logic [1:0]        sync;
    logic              en_d, tick;
    logic [PW-1:0]     phase;
    logic [CW-1:0]     cnt;
    logic [2:0]        smp;
    logic [3:0]        idx, wl, wl_eff;
    logic [1:0]        pm;
    logic              s2, sidx, ferr, fin, pb;
    logic [DATA_W-1:0] sh;
    logic              rx_s, vote, last, perr, is_brk;
`ifdef RX_NOISE_FLAG_EN
    logic              nz, noisy;
    assign noisy = smp != 3'b000 && smp != 3'b111;
`endif

    assign rx_s   = sync[1];
    assign vote   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign last   = phase == PH_LAST;
    assign wl_eff = word_len < 4'd5 ? 4'd5 : word_len > 4'(DATA_W) ? 4'(DATA_W) : word_len;
    assign perr   = pm == 2'b01 ? ^{sh, pb} : pm == 2'b10 ? ~^{sh, pb} : pm == 2'b11 ? ~pb : 1'b0;
    assign is_brk = sh == '0 && !pb && ferr;
    assign state  = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync              <= 2'b11;
            en_d              <= 1'b0;
            tick              <= 1'b0;
            st                <= IDLE;
            phase             <= '0;
            cnt               <= '0;
            smp               <= '0;
            idx               <= '0;
            wl                <= 4'd5;
            pm                <= '0;
            s2                <= 1'b0;
            sidx              <= 1'b0;
            ferr              <= 1'b0;
            fin               <= 1'b0;
            sh                <= '0;
            pb                <= 1'b0;
            fifo.rx_data      <= '0;
            fifo.rx_parity    <= 1'b0;
            fifo.rxwr_request <= 1'b0;
            PE                <= 1'b0;
            FE                <= 1'b0;
            BRK               <= 1'b0;
            OE                <= 1'b0;
`ifdef RX_NOISE_FLAG_EN
            nz                <= 1'b0;
            NF                <= 1'b0;
`endif
        end else begin
            sync              <= {sync[0], rxIn_pin};
            en_d              <= rx_clk_enable;
            tick              <= rx_clk_enable & ~en_d;
            fifo.rxwr_request <= 1'b0;
            if (clearPE) PE <= 1'b0;
            if (clearFE) FE <= 1'b0;
            if (clearBRK) BRK <= 1'b0;
            if (clearOE) OE <= 1'b0;
`ifdef RX_NOISE_FLAG_EN
            if (clearNF) NF <= 1'b0;
`endif
            // Frame completion runs on the clk after the last stop-bit tick; set wins over clear.
            if (fin) begin
                fin <= 1'b0;
                if (is_brk) begin
                    BRK <= 1'b1;
                    cnt <= '0;
                    st  <= BREAK;
                end else begin
                    if (ferr) FE <= 1'b1;
                    if (perr) PE <= 1'b1;
                    if (fifo.rx_full) OE <= 1'b1;
                    else fifo.rxwr_request <= 1'b1;
                    fifo.rx_data   <= sh;
                    fifo.rx_parity <= pb;
                    st             <= HUNT;
                end
`ifdef RX_NOISE_FLAG_EN
                if (nz) NF <= 1'b1;
`endif
            end else if (tick) begin
                phase <= last ? '0 : phase + 1'b1;
                if (phase == PH_S0) smp[0] <= rx_s;
                if (phase == PH_S1) smp[1] <= rx_s;
                if (phase == PH_S2) smp[2] <= rx_s;
`ifdef RX_NOISE_FLAG_EN
                if (last && noisy && st inside {START, DATA, PARITY, STOP}) nz <= 1'b1;
`endif
                case (st)
                    IDLE, BREAK: begin
                        if (!rx_s) cnt <= '0;
                        else if (cnt == ONES_LAST) begin
                            cnt <= '0;
                            st  <= HUNT;
                        end else cnt <= cnt + 1'b1;
                    end
                    HUNT: begin
                        if (!rx_s) begin
                            st    <= START;
                            phase <= '0;
                            sh    <= '0;
                            pb    <= 1'b0;
                            ferr  <= 1'b0;
                            sidx  <= 1'b0;
`ifdef RX_NOISE_FLAG_EN
                            nz    <= 1'b0;
`endif
                        end
                    end
                    START: begin
                        if (last && vote) begin
                            cnt <= '0;
                            st  <= IDLE;
                        end else if (last) begin
                            idx <= '0;
                            wl  <= wl_eff;
                            pm  <= parity_mode;
                            s2  <= stop2;
                            st  <= DATA;
                        end
                    end
                    DATA: begin
                        if (last) begin
                            sh  <= sh | (DATA_W'(vote) << idx);
                            idx <= idx + 1'b1;
                            if (idx == wl - 4'd1) st <= pm != 2'b00 ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (last) begin
                            pb <= vote;
                            st <= STOP;
                        end
                    end
                    STOP: begin
                        if (last) begin
                            if (!vote) ferr <= 1'b1;
                            if (s2 && !sidx) sidx <= 1'b1;
                            else fin <= 1'b1;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven frames checked through a strobe scoreboard, plus break, glitch,
// overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int DW = 9;

    logic       clk = 1'b0, reset = 1'b1, rx_clk_enable = 1'b0, stop2 = 1'b0, rxIn_pin = 1'b1;
    logic [3:0] word_len = 4'd8;
    logic [1:0] parity_mode = 2'd0;
    logic       PE, FE, BRK, OE;
    logic       clearPE = 1'b0, clearFE = 1'b0, clearBRK = 1'b0, clearOE = 1'b0;
    logic [2:0] state;
`ifdef RX_NOISE_FLAG_EN
    logic       NF, clearNF = 1'b0;
`endif

    uart_rx_core_if #(.DATA_W(DW)) fifo ();

    uart_rx_core #(.DATA_W(DW), .OVERSAMPLE(16), .IDLE_ONES(8)) dut (
        .clk(clk), .reset(reset), .rx_clk_enable(rx_clk_enable), .word_len(word_len),
        .parity_mode(parity_mode), .stop2(stop2), .rxIn_pin(rxIn_pin), .fifo(fifo),
        .PE(PE), .FE(FE), .BRK(BRK), .OE(OE),
        .clearPE(clearPE), .clearFE(clearFE), .clearBRK(clearBRK), .clearOE(clearOE),
`ifdef RX_NOISE_FLAG_EN
        .NF(NF), .clearNF(clearNF),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        int         nb;
        logic [3:0] wl;
        logic [1:0] pm;
        logic       s2;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_par;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic [8:0] data;
        logic       par;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t v[9];
    int   checks = 0, errors = 0, strobes = 0;
    logic prev_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [8:0] d, input logic par, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.par  = par;
        e.pe   = pe;
        e.fe   = fe;
        sb.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            rx_clk_enable = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rx_clk_enable = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        rxIn_pin = b;
        ticks(16);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input logic [1:0] pm,
                              input logic pbit, input logic s2, input logic [1:0] stops);
        logic [8:0] dd;
        dd = d;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(dd[i]);
        if (pm != 2'd0) send_bit(pbit);
        send_bit(stops[0]);
        if (s2) send_bit(stops[1]);
        rxIn_pin = 1'b1;
        ticks(4);
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_all();
        clearPE = 1'b1; clearFE = 1'b1; clearBRK = 1'b1; clearOE = 1'b1;
`ifdef RX_NOISE_FLAG_EN
        clearNF = 1'b1;
`endif
        @(negedge clk);
        clearPE = 1'b0; clearFE = 1'b0; clearBRK = 1'b0; clearOE = 1'b0;
`ifdef RX_NOISE_FLAG_EN
        clearNF = 1'b0;
`endif
        @(negedge clk);
    endtask

    // Scoreboard side: every strobe must be one clk wide and match the oldest expected word.
    always @(negedge clk) begin
        if (fifo.rxwr_request) begin
            strobes++;
            chk("strobe_width", prev_wr, 0);
            chk("strobe_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rx_data", fifo.rx_data, mon_e.data);
                chk("rx_parity", fifo.rx_parity, mon_e.par);
                chk("PE_at_strobe", PE, mon_e.pe);
                chk("FE_at_strobe", FE, mon_e.fe);
            end
        end
        prev_wr = fifo.rxwr_request;
    end

    initial begin
        int n;
        //          data    nb wl     pm    s2    pbit  stops  exp_data pr  pe    fe
        v[0] = '{9'h0A5, 8, 4'd8,  2'd0, 1'b0, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
        v[1] = '{9'h041, 7, 4'd7,  2'd1, 1'b0, 1'b1, 2'b11, 9'h041, 1'b1, 1'b1, 1'b0};
        v[2] = '{9'h1C3, 9, 4'd9,  2'd2, 1'b1, 1'b0, 2'b01, 9'h1C3, 1'b0, 1'b0, 1'b1};
        v[3] = '{9'h1FF, 5, 4'd3,  2'd0, 1'b0, 1'b0, 2'b11, 9'h01F, 1'b0, 1'b0, 1'b0};
        v[4] = '{9'h0F0, 9, 4'd15, 2'd3, 1'b0, 1'b1, 2'b11, 9'h0F0, 1'b1, 1'b0, 1'b0};
        v[5] = '{9'h02A, 6, 4'd6,  2'd2, 1'b0, 1'b0, 2'b11, 9'h02A, 1'b0, 1'b0, 1'b0};
        v[6] = '{9'h055, 8, 4'd8,  2'd3, 1'b0, 1'b0, 2'b11, 9'h055, 1'b0, 1'b1, 1'b0};
        v[7] = '{9'h000, 8, 4'd8,  2'd1, 1'b0, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0, 1'b0};
        v[8] = '{9'h0C3, 8, 4'd8,  2'd1, 1'b1, 1'b0, 2'b10, 9'h0C3, 1'b0, 1'b0, 1'b1};

        fifo.rx_full = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rx_data", fifo.rx_data, 0);
        chk("reset_strobe", fifo.rxwr_request, 0);
        chk("reset_flags", {PE, FE, BRK, OE}, 0);
        chk("reset_state", state, 0);
        ticks(10);
        chk("idle_to_hunt", state, 1);

        for (int i = 0; i < 9; i++) begin
            word_len    = v[i].wl;
            parity_mode = v[i].pm;
            stop2       = v[i].s2;
            push_exp(v[i].exp_data, v[i].exp_par, v[i].exp_pe, v[i].exp_fe);
            n = strobes;
            send_frame(v[i].data, v[i].nb, v[i].pm, v[i].pbit, v[i].s2, v[i].stops);
            chk("strobe_count", strobes, n + 1);
            clear_all();
            chk("PE_cleared", PE, 0);
            chk("FE_cleared", FE, 0);
        end

        // Line held low for 20 bit times: break, no strobe, then recovery on a high line.
        word_len = 4'd8; parity_mode = 2'd0; stop2 = 1'b0;
        n = strobes;
        rxIn_pin = 1'b0;
        ticks(320);
        chk("break_flag", BRK, 1);
        chk("break_state", state, 6);
        chk("break_no_strobe", strobes, n);
        rxIn_pin = 1'b1;
        ticks(10);
        chk("break_to_hunt", state, 1);
        clear_all();
        chk("BRK_cleared", BRK, 0);
        push_exp(9'h055, 1'b0, 1'b0, 1'b0);
        n = strobes;
        send_frame(9'h055, 8, 2'd0, 1'b0, 1'b0, 2'b11);
        chk("post_break_strobe", strobes, n + 1);

        // Three-tick glitch is rejected as a false start.
        n = strobes;
        rxIn_pin = 1'b0;
        ticks(3);
        rxIn_pin = 1'b1;
        ticks(21);
        chk("glitch_state", state, 0);
        chk("glitch_no_strobe", strobes, n);
        ticks(10);
        chk("glitch_rehunt", state, 1);

        // FIFO full: overrun instead of a strobe, word still captured.
        fifo.rx_full = 1'b1;
        send_frame(9'h033, 8, 2'd0, 1'b0, 1'b0, 2'b11);
        chk("overrun_flag", OE, 1);
        chk("overrun_data", fifo.rx_data, 9'h033);
        chk("overrun_no_strobe", strobes, n);
        fifo.rx_full = 1'b0;

        // Reset in the middle of data bit 3 aborts the frame and clears every output.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rxIn_pin = 1'b1;
        ticks(8);
        chk("midframe_state", state, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_rx_data", fifo.rx_data, 0);
        chk("mid_reset_parity", fifo.rx_parity, 0);
        chk("mid_reset_strobe", fifo.rxwr_request, 0);
        chk("mid_reset_flags", {PE, FE, BRK, OE}, 0);
        chk("mid_reset_state", state, 0);
        chk("mid_reset_no_strobe", strobes, n);
        ticks(10);
        push_exp(9'h07E, 1'b0, 1'b0, 1'b0);
        send_frame(9'h07E, 8, 2'd0, 1'b0, 1'b0, 2'b11);
        chk("post_reset_strobe", strobes, n + 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
